r2n_buffer: RTL

Ready-to-normal buffer. It accepts block-chunked result data from the multi-core matrix multiplier and reassembles it into plain row-major matrix rows, emitting one full row per transfer. It sits between the MAC core array output and any consumer that expects normal row-by-row matrices, such as the next layer's input buffer or a writeback path. It is the inverse of the normal-to-ready chunking stage.

---
 rtl/r2n_pkg.sv | 43 ++++
 rtl/r2n_buffer_if.sv | 32 +++
 rtl/r2n_slice_bank.sv | 62 ++++++
 rtl/r2n_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/r2n_pkg.sv
// rtl/r2n_pkg.sv - shared types and index helpers for the ready-to-normal buffer
//
// Purpose: state enum, derived-size functions and the lane/element bit-offset
//          helpers shared with the normal-to-ready chunking stage.
// Ports:   none (package).
package r2n_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } r2n_state_t;

    // Rows covered by one slice: every core contributes one block of rows.
    function automatic int slice_rows(input int block_size, input int num_cores);
        return block_size * num_cores;
    endfunction

    // Input beats needed to fill one slice across all columns.
    function automatic int chunks_per_row(input int col, input int block_size);
        return col / block_size;
    endfunction

    // Counter width that stays legal when the count range collapses to 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Core k sits in the MSBs when k == 0.
    function automatic int lane_lsb(input int k, input int num_cores, input int chunk_w);
        return (num_cores - 1 - k) * chunk_w;
    endfunction

    // Element e of a chunk; element 0 is in the chunk MSBs.
    function automatic int elem_lsb(input int e, input int chunk_size, input int width);
        return (chunk_size - 1 - e) * width;
    endfunction

    // Column c of a row; column 0 is in the row MSBs.
    function automatic int col_lsb(input int c, input int col, input int width);
        return (col - 1 - c) * width;
    endfunction

endpackage

// File: rtl/r2n_buffer_if.sv
// rtl/r2n_buffer_if.sv - chunk-in / row-out handshake bundle for r2n_buffer
//
// Purpose: groups the input chunk stream, output row stream and done pulses.
// Signals: in_valid/in_ready/in_r2n_buffer  chunk beat (one chunk per core)
//          out_valid/out_ready/out_r2n_buffer  one row-major matrix row
//          slice_done, matrix_done  one-cycle completion pulses
// Modports: master = producer/consumer side (bench), slave = r2n_buffer.
interface r2n_buffer_if #(
    parameter int WIDTH      = 16,
    parameter int CHUNK_SIZE = 4,
    parameter int NUM_CORES  = 2,
    parameter int COL        = 4
);
    logic                                in_valid;
    logic                                in_ready;
    logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_r2n_buffer;
    logic                                out_valid;
    logic                                out_ready;
    logic [WIDTH*COL-1:0]                out_r2n_buffer;
    logic                                slice_done;
    logic                                matrix_done;

    modport master (
        output in_valid, in_r2n_buffer, out_ready,
        input  in_ready, out_valid, out_r2n_buffer, slice_done, matrix_done
    );

    modport slave (
        input  in_valid, in_r2n_buffer, out_ready,
        output in_ready, out_valid, out_r2n_buffer, slice_done, matrix_done
    );
endinterface

// File: rtl/r2n_slice_bank.sv
// rtl/r2n_slice_bank.sv - SLICE_ROWS x COL element store with chunk scatter and row read
//
// Purpose: one beat writes every core's BLOCK_SIZE x BLOCK_SIZE chunk into the
//          block column selected by i_wr_chunk; the read port returns one row.
// Ports:   clk         clock
//          i_wr_en     write the beat on this edge
//          i_wr_chunk  block-column index of the beat
//          i_wr_data   NUM_CORES chunks, core 0 in the MSBs
//          i_rd_row    row to present on o_rd_data
//          o_rd_data   row, column 0 in the MSBs (combinational read)
module r2n_slice_bank
    import r2n_pkg::*;
#(
    parameter  int WIDTH          = 16,
    parameter  int BLOCK_SIZE     = 2,
    parameter  int CHUNK_SIZE     = 4,
    parameter  int NUM_CORES      = 2,
    parameter  int COL            = 4,
    localparam int SLICE_ROWS     = slice_rows(BLOCK_SIZE, NUM_CORES),
    localparam int CHUNKS_PER_ROW = chunks_per_row(COL, BLOCK_SIZE),
    localparam int CW             = cnt_w(CHUNKS_PER_ROW),
    localparam int RW             = cnt_w(SLICE_ROWS),
    localparam int CHUNK_W        = WIDTH * CHUNK_SIZE
) (
    input  logic                           clk,
    input  logic                           i_wr_en,
    input  logic [CW-1:0]                  i_wr_chunk,
    input  logic [CHUNK_W*NUM_CORES-1:0]   i_wr_data,
    input  logic [RW-1:0]                  i_rd_row,
    output logic [WIDTH*COL-1:0]           o_rd_data
);

    // Contents are never reset: a slice is always fully rewritten before it drains.
    logic [WIDTH-1:0] r_mem [SLICE_ROWS][COL];

    // Loop over all columns and keep the ones in the addressed block column,
    // so every array index stays a loop constant.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                for (int r = 0; r < BLOCK_SIZE; r++) begin
                    for (int c = 0; c < COL; c++) begin
                        if ((c / BLOCK_SIZE) == int'(i_wr_chunk)) begin
                            r_mem[k*BLOCK_SIZE + r][c] <= i_wr_data[
                                lane_lsb(k, NUM_CORES, CHUNK_W) +
                                elem_lsb(r*BLOCK_SIZE + (c % BLOCK_SIZE), CHUNK_SIZE, WIDTH)
                                +: WIDTH];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int c = 0; c < COL; c++) begin
            o_rd_data[col_lsb(c, COL, WIDTH) +: WIDTH] = r_mem[i_rd_row][c];
        end
    end

endmodule

// File: rtl/r2n_buffer.sv
// rtl/r2n_buffer.sv - reassembles per-core block chunks into row-major matrix rows
//
// Purpose: COLLECT scatters CHUNKS_PER_ROW beats into a slice bank, DRAIN emits
//          SLICE_ROWS rows; slice_done/matrix_done pulse after the last row of
//          a slice/matrix is accepted.
// Ports:   clk    clock
//          rst_n  asynchronous active-low reset
//          bus    r2n_buffer_if.slave (chunk input, row output, done pulses)
// Option:  R2N_PINGPONG_EN - two banks, one collects while the other drains.
module r2n_buffer
    import r2n_pkg::*;
#(
    parameter  int WIDTH          = 16,
    parameter  int FRAC_WIDTH     = 8,
    parameter  int BLOCK_SIZE     = 2,
    parameter  int CHUNK_SIZE     = 4,
    parameter  int ROW            = 8,
    parameter  int COL            = 4,
    parameter  int NUM_CORES      = 2,
    localparam int SLICE_ROWS     = slice_rows(BLOCK_SIZE, NUM_CORES),
    localparam int CHUNKS_PER_ROW = chunks_per_row(COL, BLOCK_SIZE),
    localparam int NUM_SLICES     = ROW / SLICE_ROWS,
    localparam int CW             = cnt_w(CHUNKS_PER_ROW),
    localparam int RW             = cnt_w(SLICE_ROWS),
    localparam int SW             = cnt_w(NUM_SLICES)
) (
    input  logic     clk,
    input  logic     rst_n,
    r2n_buffer_if.slave bus
);

    if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_bad_chunk
        $error("r2n_buffer: CHUNK_SIZE must equal BLOCK_SIZE*BLOCK_SIZE");
    end
    if ((ROW % SLICE_ROWS) != 0) begin : g_bad_row
        $error("r2n_buffer: ROW must be a multiple of BLOCK_SIZE*NUM_CORES");
    end
    if ((COL % BLOCK_SIZE) != 0) begin : g_bad_col
        $error("r2n_buffer: COL must be a multiple of BLOCK_SIZE");
    end
    // Data is passed through untouched; the fraction only has to fit the word.
    if (FRAC_WIDTH > WIDTH) begin : g_bad_frac
        $error("r2n_buffer: FRAC_WIDTH exceeds WIDTH");
    end

    logic [CW-1:0]        r_chunk_cnt;
    logic [RW-1:0]        r_row_cnt;
    logic [SW-1:0]        r_slice_cnt;
    logic                 r_slice_done;
    logic                 r_matrix_done;

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_last_chunk;
    logic                 w_last_row;
    logic                 w_last_slice;
    logic [WIDTH*COL-1:0] w_rd_data;

    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_xfer       = w_out_valid & bus.out_ready;
    assign w_last_chunk = (r_chunk_cnt == CW'(CHUNKS_PER_ROW - 1));
    assign w_last_row   = (r_row_cnt == RW'(SLICE_ROWS - 1));
    assign w_last_slice = (r_slice_cnt == SW'(NUM_SLICES - 1));

`ifdef R2N_PINGPONG_EN
    // Each bank is COLLECT (free/filling) or DRAIN (complete, not yet emitted).
    // The write pointer only lands on a DRAIN bank when both banks are full.
    r2n_state_t           r_bank_st [2];
    logic                 r_wr_bank;
    logic                 r_rd_bank;
    logic [WIDTH*COL-1:0] w_rd_data0;
    logic [WIDTH*COL-1:0] w_rd_data1;

    assign w_in_ready  = (r_bank_st[r_wr_bank] == COLLECT);
    assign w_out_valid = (r_bank_st[r_rd_bank] == DRAIN);
    assign w_rd_data   = r_rd_bank ? w_rd_data1 : w_rd_data0;

    r2n_slice_bank #(
        .WIDTH(WIDTH), .BLOCK_SIZE(BLOCK_SIZE), .CHUNK_SIZE(CHUNK_SIZE),
        .NUM_CORES(NUM_CORES), .COL(COL)
    ) u_bank0 (
        .clk        (clk),
        .i_wr_en    (w_accept & ~r_wr_bank),
        .i_wr_chunk (r_chunk_cnt),
        .i_wr_data  (bus.in_r2n_buffer),
        .i_rd_row   (r_row_cnt),
        .o_rd_data  (w_rd_data0)
    );

    r2n_slice_bank #(
        .WIDTH(WIDTH), .BLOCK_SIZE(BLOCK_SIZE), .CHUNK_SIZE(CHUNK_SIZE),
        .NUM_CORES(NUM_CORES), .COL(COL)
    ) u_bank1 (
        .clk        (clk),
        .i_wr_en    (w_accept & r_wr_bank),
        .i_wr_chunk (r_chunk_cnt),
        .i_wr_data  (bus.in_r2n_buffer),
        .i_rd_row   (r_row_cnt),
        .o_rd_data  (w_rd_data1)
    );
`else
    r2n_state_t r_state;

    assign w_in_ready  = (r_state == COLLECT);
    assign w_out_valid = (r_state == DRAIN);

    r2n_slice_bank #(
        .WIDTH(WIDTH), .BLOCK_SIZE(BLOCK_SIZE), .CHUNK_SIZE(CHUNK_SIZE),
        .NUM_CORES(NUM_CORES), .COL(COL)
    ) u_bank0 (
        .clk        (clk),
        .i_wr_en    (w_accept),
        .i_wr_chunk (r_chunk_cnt),
        .i_wr_data  (bus.in_r2n_buffer),
        .i_rd_row   (r_row_cnt),
        .o_rd_data  (w_rd_data)
    );
`endif

    // Collect and drain sides update independently; in ping-pong mode they
    // always address different banks when both fire in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chunk_cnt   <= '0;
            r_row_cnt     <= '0;
            r_slice_cnt   <= '0;
            r_slice_done  <= 1'b0;
            r_matrix_done <= 1'b0;
`ifdef R2N_PINGPONG_EN
            r_bank_st[0]  <= COLLECT;
            r_bank_st[1]  <= COLLECT;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
`else
            r_state       <= COLLECT;
`endif
        end else begin
            r_slice_done  <= 1'b0;
            r_matrix_done <= 1'b0;

            if (w_accept) begin
                if (w_last_chunk) begin
                    r_chunk_cnt <= '0;
`ifdef R2N_PINGPONG_EN
                    r_bank_st[r_wr_bank] <= DRAIN;
                    r_wr_bank            <= ~r_wr_bank;
`else
                    r_state <= DRAIN;
`endif
                end else begin
                    r_chunk_cnt <= r_chunk_cnt + CW'(1);
                end
            end

            if (w_xfer) begin
                if (w_last_row) begin
                    r_row_cnt    <= '0;
                    r_slice_done <= 1'b1;
                    if (w_last_slice) begin
                        r_slice_cnt   <= '0;
                        r_matrix_done <= 1'b1;
                    end else begin
                        r_slice_cnt <= r_slice_cnt + SW'(1);
                    end
`ifdef R2N_PINGPONG_EN
                    r_bank_st[r_rd_bank] <= COLLECT;
                    r_rd_bank            <= ~r_rd_bank;
`else
                    r_state <= COLLECT;
`endif
                end else begin
                    r_row_cnt <= r_row_cnt + RW'(1);
                end
            end
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_r2n_buffer = w_out_valid ? w_rd_data : '0;
    assign bus.slice_done     = r_slice_done;
    assign bus.matrix_done    = r_matrix_done;

endmodule
